// File: rtl/calc_sequencer.sv
// Control FSM for the matrix calculator: edge-detects key levels, sequences operand entry,
// ALU run and result display. Optional result chaining is enabled by defining CALC_CHAIN_EN.
module calc_sequencer #(
    parameter int ELEMS  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [2:0]        op_code,
    input  logic              is_op,
    input  logic              is_enter,
    input  logic              alu_done,
    output logic              wr_en,
    output logic              wr_sel,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [2:0]        alu_op,
    output logic              alu_start,
    output logic              busy,
    output logic              disp_result,
    output logic              err,
    output logic              chain
);

    typedef enum logic [2:0] {
        ENTER_A,
        WAIT_OP,
        ENTER_B,
        COMPUTE,
        SHOW
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(ELEMS - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                prev_enter_q, prev_enter_d;
    logic                prev_op_q, prev_op_d;
    logic                wr_en_q, wr_en_d;
    logic                wr_sel_q, wr_sel_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [2:0]          alu_op_q, alu_op_d;
    logic                alu_start_q, alu_start_d;
    logic                err_q, err_d;
    logic                enter_ev, op_ev, op_valid;
`ifdef CALC_CHAIN_EN
    logic                chain_q, chain_d;
`endif

    assign enter_ev = is_enter & ~prev_enter_q;
    assign op_ev    = is_op & ~prev_op_q;
    assign op_valid = (op_code == 3'b001) || (op_code == 3'b010);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        prev_enter_d = is_enter;
        prev_op_d    = is_op;
        wr_en_d      = 1'b0;
        wr_sel_d     = 1'b0;
        wr_addr_d    = '0;
        alu_op_d     = alu_op_q;
        alu_start_d  = 1'b0;
        err_d        = err_q;
`ifdef CALC_CHAIN_EN
        chain_d      = 1'b0;
`endif
        case (state_q)
            ENTER_A, ENTER_B: begin
                if (enter_ev) begin
                    wr_en_d   = 1'b1;
                    wr_sel_d  = (state_q == ENTER_B);
                    wr_addr_d = idx_q;
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if (state_q == ENTER_A) begin
                            state_d = WAIT_OP;
                        end else begin
                            state_d     = COMPUTE;
                            alu_start_d = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            WAIT_OP: begin
                if (op_ev) begin
                    if (op_valid) begin
                        alu_op_d = op_code;
                        err_d    = 1'b0;
                        state_d  = ENTER_B;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            COMPUTE: begin
                if (alu_done) state_d = SHOW;
            end
            SHOW: begin
                if (enter_ev) begin
                    state_d = ENTER_A;
                    idx_d   = '0;
                end
`ifdef CALC_CHAIN_EN
                // Chained op: the datapath moves the result into A, so only B is entered next.
                else if (op_ev) begin
                    if (op_valid) begin
                        alu_op_d = op_code;
                        err_d    = 1'b0;
                        chain_d  = 1'b1;
                        idx_d    = '0;
                        state_d  = ENTER_B;
                    end else begin
                        err_d = 1'b1;
                    end
                end
`endif
            end
            default: begin
                state_d = ENTER_A;
                idx_d   = '0;
            end
        endcase
    end

    // Key history resets high so a key held through reset release is not seen as a press.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= ENTER_A;
            idx_q        <= '0;
            prev_enter_q <= 1'b1;
            prev_op_q    <= 1'b1;
            wr_en_q      <= 1'b0;
            wr_sel_q     <= 1'b0;
            wr_addr_q    <= '0;
            alu_op_q     <= 3'b000;
            alu_start_q  <= 1'b0;
            err_q        <= 1'b0;
`ifdef CALC_CHAIN_EN
            chain_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            prev_enter_q <= prev_enter_d;
            prev_op_q    <= prev_op_d;
            wr_en_q      <= wr_en_d;
            wr_sel_q     <= wr_sel_d;
            wr_addr_q    <= wr_addr_d;
            alu_op_q     <= alu_op_d;
            alu_start_q  <= alu_start_d;
            err_q        <= err_d;
`ifdef CALC_CHAIN_EN
            chain_q      <= chain_d;
`endif
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_sel      = wr_sel_q;
    assign wr_addr     = wr_addr_q;
    assign alu_op      = alu_op_q;
    assign alu_start   = alu_start_q;
    assign busy        = (state_q == COMPUTE);
    assign disp_result = (state_q == SHOW);
    assign err         = err_q;
`ifdef CALC_CHAIN_EN
    assign chain       = chain_q;
`else
    assign chain       = 1'b0;
`endif

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: a table of per-cycle vectors plus hand sequences for
// held keys, reset mid-operation and the SHOW-state operator press (both CALC_CHAIN_EN builds).
module tb_calc_sequencer;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic [2:0] op_code = 3'b000;
    logic       is_op = 1'b0;
    logic       is_enter = 1'b0;
    logic       alu_done = 1'b0;
    logic       wr_en, wr_sel, alu_start, busy, disp_result, err, chain;
    logic [1:0] wr_addr;
    logic [2:0] alu_op;

    calc_sequencer #(.ELEMS(4), .ADDR_W(2)) dut (
        .clk(clk), .nrst(nrst), .op_code(op_code), .is_op(is_op), .is_enter(is_enter),
        .alu_done(alu_done), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .alu_op(alu_op), .alu_start(alu_start), .busy(busy), .disp_result(disp_result),
        .err(err), .chain(chain)
    );

    always #5 clk = ~clk;

    // {wr_en, wr_sel, wr_addr, alu_op, alu_start, busy, disp_result, err, chain}
    logic [11:0] outs;
    assign outs = {wr_en, wr_sel, wr_addr, alu_op, alu_start, busy, disp_result, err, chain};

    typedef struct {
        logic        enter;
        logic        op;
        logic [2:0]  code;
        logic        done;
        logic [11:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [11:0] o(input logic w, input logic s, input int a,
                                      input logic [2:0] aop, input logic st, input logic bs,
                                      input logic dp, input logic er, input logic ch);
        logic [1:0] ad;
        ad = a[1:0];
        return {w, s, ad, aop, st, bs, dp, er, ch};
    endfunction

    task automatic add(input logic e, input logic p, input logic [2:0] c, input logic d,
                       input logic [11:0] x);
        vec_t v;
        v.enter = e; v.op = p; v.code = c; v.done = d; v.exp = x;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic cyc(input logic e, input logic p, input logic [2:0] c, input logic d);
        is_enter = e; is_op = p; op_code = c; alu_done = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        is_enter = 1'b0; is_op = 1'b0; op_code = 3'b000; alu_done = 1'b0;
        nrst = 1'b0;
        @(posedge clk);
        #1;
        nrst = 1'b1;
        cyc(0, 0, 3'b000, 0);
    endtask

    // Leaves the DUT one cycle into COMPUTE (alu_start pulse already seen)
    task automatic run_to_compute(input logic [2:0] code);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 3'b000, 0);
            cyc(0, 0, 3'b000, 0);
        end
        cyc(0, 1, code, 0);
        cyc(0, 0, 3'b000, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 3'b000, 0);
            cyc(0, 0, 3'b000, 0);
        end
    endtask

    initial begin
        int cnt;

        // Main calculation table, one row per clock
        add(0, 0, 3'b000, 0, o(0,0,0,3'b000,0,0,0,0,0));
        add(0, 0, 3'b000, 1, o(0,0,0,3'b000,0,0,0,0,0));
        for (int i = 0; i < 4; i++) begin
            add(1, 0, 3'b000, 0, o(1,0,i,3'b000,0,0,0,0,0));
            add(0, (i == 1), 3'b001, 0, o(0,0,0,3'b000,0,0,0,0,0));
        end
        add(1, 0, 3'b000, 0, o(0,0,0,3'b000,0,0,0,0,0));
        add(0, 0, 3'b000, 0, o(0,0,0,3'b000,0,0,0,0,0));
        add(0, 1, 3'b011, 0, o(0,0,0,3'b000,0,0,0,1,0));
        add(0, 0, 3'b000, 0, o(0,0,0,3'b000,0,0,0,1,0));
        add(1, 1, 3'b111, 0, o(0,0,0,3'b000,0,0,0,1,0));
        add(0, 0, 3'b000, 0, o(0,0,0,3'b000,0,0,0,1,0));
        add(0, 1, 3'b010, 0, o(0,0,0,3'b010,0,0,0,0,0));
        add(0, 0, 3'b000, 0, o(0,0,0,3'b010,0,0,0,0,0));
        for (int i = 0; i < 4; i++) begin
            add(1, (i == 0), 3'b001, 0, o(1,1,i,3'b010,(i == 3),(i == 3),0,0,0));
            add(0, 0, 3'b000, 0, o(0,0,0,3'b010,0,(i == 3),0,0,0));
        end
        add(1, 1, 3'b001, 0, o(0,0,0,3'b010,0,1,0,0,0));
        add(0, 0, 3'b000, 0, o(0,0,0,3'b010,0,1,0,0,0));
        add(0, 0, 3'b000, 1, o(0,0,0,3'b010,0,0,1,0,0));
        add(0, 0, 3'b000, 1, o(0,0,0,3'b010,0,0,1,0,0));
        add(1, 1, 3'b001, 0, o(0,0,0,3'b010,0,0,0,0,0));
        add(0, 0, 3'b000, 0, o(0,0,0,3'b010,0,0,0,0,0));
        add(1, 0, 3'b000, 0, o(1,0,0,3'b010,0,0,0,0,0));
        add(0, 0, 3'b000, 0, o(0,0,0,3'b010,0,0,0,0,0));

        // Reset state, checked while nrst is still low
        nrst = 1'b0;
        #12;
        check("reset_outputs", 32'(outs), 32'(o(0,0,0,3'b000,0,0,0,0,0)));
        @(posedge clk);
        #1;
        nrst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].enter, tbl[i].op, tbl[i].code, tbl[i].done);
            check($sformatf("row%0d", i), 32'(outs), 32'(tbl[i].exp));
        end

        // Enter held for 10 cycles gives one write
        do_reset();
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1, 0, 3'b000, 0);
            cnt += int'(wr_en);
        end
        check("held_enter_writes", 32'(cnt), 32'd1);
        cyc(0, 0, 3'b000, 0);

        // Enter held across reset release gives no write
        is_enter = 1'b1;
        nrst = 1'b0;
        @(posedge clk);
        #1;
        nrst = 1'b1;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 3'b000, 0);
            cnt += int'(wr_en);
        end
        check("enter_through_reset_writes", 32'(cnt), 32'd0);
        cyc(0, 0, 3'b000, 0);
        cyc(1, 0, 3'b000, 0);
        check("first_write_after_reset", 32'(outs), 32'(o(1,0,0,3'b000,0,0,0,0,0)));
        cyc(0, 0, 3'b000, 0);

        // Reset mid-COMPUTE aborts; a late alu_done is ignored
        do_reset();
        run_to_compute(3'b001);
        check("compute_busy", 32'(outs), 32'(o(0,0,0,3'b001,0,1,0,0,0)));
        nrst = 1'b0;
        #2;
        check("reset_mid_compute", 32'(outs), 32'(o(0,0,0,3'b000,0,0,0,0,0)));
        @(posedge clk);
        #1;
        nrst = 1'b1;
        cyc(0, 0, 3'b000, 0);
        cyc(0, 0, 3'b000, 1);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 3'b000, 0);
            cnt += int'(alu_start) + int'(busy) + int'(disp_result);
        end
        check("late_done_ignored", 32'(outs), 32'(o(0,0,0,3'b000,0,0,0,0,0)));
        check("no_activity_after_abort", 32'(cnt), 32'd0);

        // alu_done six cycles after start, then operator press in SHOW
        do_reset();
        run_to_compute(3'b001);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 3'b000, 0);
            cnt += int'(busy) + int'(alu_start);
        end
        check("busy_while_waiting", 32'(cnt), 32'd4);
        cyc(0, 0, 3'b000, 1);
        check("done_to_show", 32'(outs), 32'(o(0,0,0,3'b001,0,0,1,0,0)));
        cyc(0, 0, 3'b000, 0);
        cyc(0, 1, 3'b010, 0);
`ifdef CALC_CHAIN_EN
        check("show_op_chain", 32'(outs), 32'(o(0,0,0,3'b010,0,0,0,0,1)));
        cyc(0, 0, 3'b000, 0);
        check("chain_one_cycle", 32'(outs), 32'(o(0,0,0,3'b010,0,0,0,0,0)));
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 3'b000, 0);
            check($sformatf("chain_b_write%0d", i), 32'(outs),
                  32'(o(1,1,i,3'b010,(i == 3),(i == 3),0,0,0)));
            cyc(0, 0, 3'b000, 0);
        end
`else
        check("show_op_ignored", 32'(outs), 32'(o(0,0,0,3'b001,0,0,1,0,0)));
        cyc(0, 0, 3'b000, 0);
        check("show_op_still_show", 32'(outs), 32'(o(0,0,0,3'b001,0,0,1,0,0)));
        cyc(1, 0, 3'b000, 0);
        check("show_enter_leaves", 32'(outs), 32'(o(0,0,0,3'b001,0,0,0,0,0)));
        cyc(0, 0, 3'b000, 0);
        cyc(1, 0, 3'b000, 0);
        check("new_calc_write_a0", 32'(outs), 32'(o(1,0,0,3'b001,0,0,0,0,0)));
        cyc(0, 0, 3'b000, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
